// File: rtl/simple_maxpool_col_unit_pkg.sv
// ============================================================================
// Module  : simple_maxpool_col_unit_pkg
// Brief   : Shared hyper-parameters and types for the vertical maxpool unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package simple_maxpool_col_unit_pkg;

  localparam int IMG_WIDTH  = 32;
  localparam int TIME_STEPS = 4;
  localparam int ROW_W      = IMG_WIDTH * TIME_STEPS;
  localparam int ROW_CNT_W  = 7;
  localparam int CH_CNT_W   = 16;
  localparam int CFG_W      = 16;

  typedef logic [ROW_W-1:0] row_t;

  typedef struct packed {
    logic [CFG_W-1:0] in_ch;
    logic [CFG_W-1:0] img_size;
  } layer_cfg_t;

  function automatic logic is_last_row(input logic [ROW_CNT_W-1:0] cnt,
                                       input logic [CFG_W-1:0]     size);
    return {{(CFG_W-ROW_CNT_W){1'b0}}, cnt} == (size - {{(CFG_W-1){1'b0}}, 1'b1});
  endfunction

endpackage

`default_nettype wire

// File: rtl/simple_maxpool_col_unit_if.sv
// ============================================================================
// Module  : simple_maxpool_col_unit_if
// Brief   : Configuration, row-input and pooled-output bundle of the unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface simple_maxpool_col_unit_if;
  import simple_maxpool_col_unit_pkg::*;

  logic             code_valid;
  logic [CFG_W-1:0] conv_in_ch;
  logic [CFG_W-1:0] conv_img_size;
  logic             i_row_valid;
  row_t             i_row_data;
  logic             o_pool_valid;
  row_t             o_pool_data;
  logic             o_frame_done;
  logic             o_layer_done;
  logic             o_calculating_flag;

  modport slave (
    input  code_valid, conv_in_ch, conv_img_size, i_row_valid, i_row_data,
    output o_pool_valid, o_pool_data, o_frame_done, o_layer_done, o_calculating_flag
  );

  modport master (
    output code_valid, conv_in_ch, conv_img_size, i_row_valid, i_row_data,
    input  o_pool_valid, o_pool_data, o_frame_done, o_layer_done, o_calculating_flag
  );

endinterface

`default_nettype wire

// File: rtl/simple_maxpool_col_unit.sv
// ============================================================================
// Module  : simple_maxpool_col_unit
// Brief   : Vertical 3-row / stride-2 OR-pool of horizontally pooled spike rows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simple_maxpool_col_unit
  import simple_maxpool_col_unit_pkg::*;
(
  input  logic                      s_clk,
  input  logic                      s_rst,
  simple_maxpool_col_unit_if.slave  bus
);

  layer_cfg_t           r_cfg;
  row_t                 r_hold;
  row_t                 r_acc;
  row_t                 r_pool_data;
  logic [ROW_CNT_W-1:0] r_row_cnt;
  logic [CH_CNT_W-1:0]  r_ch_cnt;
  logic                 r_pool_valid;
  logic                 r_frame_done;
  logic                 r_layer_done;
  logic                 r_calc_flag;

  logic                 w_row_accept;
  logic                 w_last_row;
  logic                 w_last_ch;
  logic [CH_CNT_W-1:0]  w_ch_cnt_inc;
  logic [ROW_CNT_W-1:0] w_row_cnt_next;

  // A zero stored size means no layer is configured (reset state), so rows are dropped.
  assign w_row_accept = bus.i_row_valid && !bus.code_valid && (r_cfg.img_size != '0);
  assign w_last_row   = is_last_row(r_row_cnt, r_cfg.img_size);
  assign w_ch_cnt_inc = r_ch_cnt + {{(CH_CNT_W-1){1'b0}}, 1'b1};
  assign w_last_ch    = (w_ch_cnt_inc == r_cfg.in_ch);

  always_comb begin
    w_row_cnt_next = r_row_cnt;
    if (bus.code_valid) begin
      w_row_cnt_next = '0;
    end else if (w_row_accept) begin
      w_row_cnt_next = w_last_row ? '0 : r_row_cnt + {{(ROW_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_cfg        <= '0;
      r_hold       <= '0;
      r_acc        <= '0;
      r_pool_data  <= '0;
      r_row_cnt    <= '0;
      r_ch_cnt     <= '0;
      r_pool_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_layer_done <= 1'b0;
      r_calc_flag  <= 1'b0;
    end else begin
      r_pool_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_layer_done <= 1'b0;
      r_row_cnt    <= w_row_cnt_next;
      r_calc_flag  <= (w_row_cnt_next != '0);

      if (bus.code_valid) begin
        r_cfg.in_ch    <= bus.conv_in_ch;
        r_cfg.img_size <= bus.conv_img_size;
        r_ch_cnt       <= '0;
        r_hold         <= '0;
        r_acc          <= '0;
      end else if (w_row_accept) begin
        if (!r_row_cnt[0]) begin
          r_acc <= r_hold | bus.i_row_data;
        end else begin
          r_pool_data  <= r_acc | bus.i_row_data;
          r_pool_valid <= 1'b1;
          r_hold       <= bus.i_row_data;
        end
        // Frame end: the next frame must see a zero top pad row.
        if (w_last_row) begin
          r_hold       <= '0;
          r_frame_done <= 1'b1;
          r_layer_done <= w_last_ch;
          r_ch_cnt     <= w_last_ch ? '0 : w_ch_cnt_inc;
        end
      end
    end
  end

  assign bus.o_pool_valid       = r_pool_valid;
  assign bus.o_pool_data        = r_pool_data;
  assign bus.o_frame_done       = r_frame_done;
  assign bus.o_layer_done       = r_layer_done;
  assign bus.o_calculating_flag = r_calc_flag;

endmodule

`default_nettype wire

// File: tb/tb_simple_maxpool_col_unit.sv
// ============================================================================
// Module  : tb_simple_maxpool_col_unit
// Brief   : Scoreboard bench for the vertical maxpool unit with directed rows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simple_maxpool_col_unit;
  import simple_maxpool_col_unit_pkg::*;

  logic s_clk = 1'b0;
  logic s_rst;
  always #5 s_clk = ~s_clk;

  simple_maxpool_col_unit_if bus();

  simple_maxpool_col_unit dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus)
  );

  typedef struct {
    row_t data;
    logic fd;
    logic ld;
    int   at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge s_clk) cyc <= cyc + 1;

  function automatic row_t lane(input int k, input logic [3:0] v);
    row_t r;
    r = '0;
    r[k*TIME_STEPS +: TIME_STEPS] = v;
    return r;
  endfunction

  function automatic row_t all_lanes(input logic [3:0] v);
    row_t r;
    r = '0;
    for (int k = 0; k < IMG_WIDTH; k++) r[k*TIME_STEPS +: TIME_STEPS] = v;
    return r;
  endfunction

  task automatic chk(input string name, input row_t act, input row_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic cfg(input int ch, input int size, input logic rv, input row_t d);
    bus.code_valid    = 1'b1;
    bus.conv_in_ch    = ch[15:0];
    bus.conv_img_size = size[15:0];
    bus.i_row_valid   = rv;
    bus.i_row_data    = d;
    @(negedge s_clk);
    bus.code_valid  = 1'b0;
    bus.i_row_valid = 1'b0;
  endtask

  // Drives one row for one cycle; an odd row can register its expected output.
  task automatic row(input row_t d, input logic exp_en, input row_t exp_d,
                     input logic fd, input logic ld);
    exp_t e;
    bus.i_row_valid = 1'b1;
    bus.i_row_data  = d;
    if (exp_en) begin
      e.data = exp_d; e.fd = fd; e.ld = ld; e.at = cyc + 1;
      sb.push_back(e);
    end
    @(negedge s_clk);
    bus.i_row_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.i_row_valid = 1'b0;
    repeat (n) @(negedge s_clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pool_valid"}, row_t'(bus.o_pool_valid), '0);
    chk({tag, "_pool_data"},  bus.o_pool_data, '0);
    chk({tag, "_frame_done"}, row_t'(bus.o_frame_done), '0);
    chk({tag, "_layer_done"}, row_t'(bus.o_layer_done), '0);
    chk({tag, "_calc_flag"},  row_t'(bus.o_calculating_flag), '0);
  endtask

  initial begin
    s_rst             = 1'b1;
    bus.code_valid    = 1'b0;
    bus.conv_in_ch    = '0;
    bus.conv_img_size = '0;
    bus.i_row_valid   = 1'b0;
    bus.i_row_data    = '0;

    fork
      forever begin
        exp_t e;
        @(negedge s_clk);
        if (bus.o_pool_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pool_valid: got valid=1 at cycle %0d required no output", cyc);
          end else begin
            e = sb.pop_front();
            chk("pool_data", bus.o_pool_data, e.data);
            chk("frame_done", row_t'(bus.o_frame_done), row_t'(e.fd));
            chk("layer_done", row_t'(bus.o_layer_done), row_t'(e.ld));
            chk_int("pool_latency_cycle", cyc, e.at);
          end
        end else if (bus.o_frame_done || bus.o_layer_done) begin
          checks++;
          errors++;
          $display("FAIL done_without_valid: got fd=%0b ld=%0b required 0", bus.o_frame_done, bus.o_layer_done);
        end
      end
    join_none

    repeat (2) @(negedge s_clk);
    chk_outputs_zero("reset");
    s_rst = 1'b0;
    idle(1);

    // Basic pooling plus calculating-flag timing; lane 31 exercises the hold path.
    cfg(1, 4, 1'b0, '0);
    chk("flag_before_row0", row_t'(bus.o_calculating_flag), '0);
    row(lane(0, 4'h1) | lane(31, 4'h8), 1'b0, '0, 1'b0, 1'b0);
    chk("flag_after_row0", row_t'(bus.o_calculating_flag), row_t'(1'b1));
    row(lane(0, 4'h2), 1'b1, lane(0, 4'h3) | lane(31, 4'h8), 1'b0, 1'b0);
    chk("flag_after_row1", row_t'(bus.o_calculating_flag), row_t'(1'b1));
    row(lane(0, 4'h4), 1'b0, '0, 1'b0, 1'b0);
    chk("flag_after_row2", row_t'(bus.o_calculating_flag), row_t'(1'b1));
    row(lane(0, 4'h8) | lane(31, 4'h1), 1'b1, lane(0, 4'hE) | lane(31, 4'h1), 1'b1, 1'b1);
    chk("flag_after_row3", row_t'(bus.o_calculating_flag), '0);
    idle(2);

    // Back-to-back rows: each output exactly one cycle after its odd row.
    cfg(1, 8, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      row(all_lanes(4'hF), i[0], all_lanes(4'hF), (i == 7), (i == 7));
    end
    idle(2);

    // Frame boundary across two channels: no leakage of frame 0's hold row.
    cfg(2, 2, 1'b0, '0);
    row(lane(0, 4'hF), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h0), 1'b1, lane(0, 4'hF), 1'b1, 1'b0);
    row(lane(0, 4'h0), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h1), 1'b1, lane(0, 4'h1), 1'b1, 1'b1);
    idle(2);

    // Config wins over a simultaneous row; pooled data is left as it was.
    cfg(1, 4, 1'b1, lane(0, 4'hF));
    chk("cfg_priority_flag", row_t'(bus.o_calculating_flag), '0);
    chk("cfg_keeps_pool_data", bus.o_pool_data, lane(0, 4'h1));
    row(lane(0, 4'h1), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h2), 1'b1, lane(0, 4'h3), 1'b0, 1'b0);
    row(lane(0, 4'h4), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h8), 1'b1, lane(0, 4'hE), 1'b1, 1'b1);
    idle(2);

    // Mid-frame reset: partial frame discarded, rows ignored until reconfigured.
    cfg(1, 6, 1'b0, '0);
    row(lane(0, 4'h5), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h2), 1'b1, lane(0, 4'h7), 1'b0, 1'b0);
    row(lane(0, 4'h8), 1'b0, '0, 1'b0, 1'b0);
    s_rst = 1'b1;
    @(negedge s_clk);
    chk_outputs_zero("midreset");
    s_rst = 1'b0;
    idle(1);
    row(lane(0, 4'h3), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h3), 1'b0, '0, 1'b0, 1'b0);
    idle(2);
    chk_outputs_zero("after_reset_rows");
    cfg(1, 2, 1'b0, '0);
    row(lane(0, 4'h4), 1'b0, '0, 1'b0, 1'b0);
    row(lane(0, 4'h1), 1'b1, lane(0, 4'h5), 1'b1, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge s_clk);
    idle(2);
    chk_int("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/simple_maxpool_col_unit.md
SIMPLE_MAXPOOL_COL_UNIT -- requirements
Module: simple_maxpool_col_unit

Interface
REQ-001 Parameters come from the shared hyper-parameter header: IMG_WIDTH (lanes per row, default 32); TIME_STEPS (spike bits per lane, default 4).
REQ-002 s_clk  in  1  clock; all state updates on the rising edge.
REQ-003 s_rst  in  1  reset, asynchronous, active-high.
REQ-004 code_valid  in  1  single-cycle pulse that loads the layer configuration.
REQ-005 conv_in_ch  in  16  number of channel frames in the layer; sampled on code_valid.
REQ-006 conv_img_size  in  16  input rows per frame; must be even, range 2..64; sampled on code_valid.
REQ-007 i_row_valid  in  1  one horizontally pooled row is present; may assert on consecutive cycles.
REQ-008 i_row_data  in  IMG_WIDTH*TIME_STEPS  horizontally pooled row; lane k occupies bits [(k+1)*TIME_STEPS-1 : k*TIME_STEPS].
REQ-009 o_pool_valid  out  1  single-cycle pulse marking one fully pooled output row.
REQ-010 o_pool_data  out  IMG_WIDTH*TIME_STEPS  pooled row; held stable until the next o_pool_valid.
REQ-011 o_frame_done  out  1  single-cycle pulse issued with the last output row of a frame.
REQ-012 o_layer_done  out  1  single-cycle pulse issued with the last output row of the last channel.
REQ-013 o_calculating_flag  out  1  high while a frame is partially received.

Function
REQ-014 Vertical window is 3 rows with stride 2 and one zero pad row on top: output row r = bitwise OR of input rows 2r-1, 2r and 2r+1 (row -1 = 0).
REQ-015 Each frame produces conv_img_size/2 output rows.
REQ-016 State is one hold register (row 2r-1), one accumulator, a row counter (7 bit) and a channel counter (16 bit).
REQ-017 Even row (counter bit0=0) accepted: acc <= hold | i_row_data.
REQ-018 Odd row accepted: o_pool_data <= acc | i_row_data; hold <= i_row_data; o_pool_valid = 1 the next cycle, giving one-cycle latency from the odd row.
REQ-019 The row counter increments on every accepted row; on the row with index conv_img_size-1 the counter wraps to 0 and hold clears to 0 so the next frame's top pad is zero.
REQ-020 o_frame_done pulses in the same cycle as the final o_pool_valid of a frame.
REQ-021 The channel counter increments on each frame end; at conv_in_ch frames it wraps to 0 and o_layer_done pulses alongside o_frame_done.
REQ-022 o_calculating_flag is registered: 1 when the row counter is non-zero, 0 otherwise.
REQ-023 code_valid has priority over a row. In that cycle the block loads the configuration, clears the counters, hold and acc, and drops any i_row_valid. o_pool_data is left unchanged.
REQ-024 Rows back-to-back at one per cycle are accepted without loss; there is no backpressure.
REQ-025 conv_img_size = 2 yields one output row per frame (rows 0 and 1 OR-ed with a zero pad).
REQ-026 Behaviour for an odd or zero conv_img_size is undefined; the bench does not drive it.

Reset
REQ-027 On s_rst: o_pool_valid, o_frame_done, o_layer_done and o_calculating_flag are 0; o_pool_data, hold and acc are 0; both counters are 0; the stored configuration is 0.
REQ-028 Reset in mid-frame discards the partial frame; operation resumes only after a new code_valid.

Structure
REQ-029 IMG_WIDTH and TIME_STEPS live in the shared hyper-parameter header; the block defines no private copies.
REQ-030 The block is flat with no sub-modules. It sits directly downstream of the horizontal maxpool row unit: i_row_valid/i_row_data connect to that unit's o_pooling_valid/o_pooling_data.

Verification
REQ-031 Test 1 (basic pooling). Setup: TIME_STEPS=4, img_size=4, conv_in_ch=1, rows 0..3 with lane 0 = 1,2,4,8. Response: output row 0 lane 0 = 0x3; output row 1 lane 0 = 0xE; o_frame_done and o_layer_done pulse with the second output row.
REQ-032 Test 2 (back-to-back rows). Setup: 8 rows driven on consecutive cycles, all lanes = 0xF. Response: 4 o_pool_valid pulses, each exactly one cycle after rows 1, 3, 5 and 7, with data all 0xF.
REQ-033 Test 3 (frame boundary). Setup: 2 channels, img_size=2; frame 0 rows = 0xF, 0x0; frame 1 rows = 0x0, 0x1. Response: frame 1 output = 0x1, confirming no leakage from frame 0's hold register; o_layer_done pulses once, after frame 1.
REQ-034 Test 4 (config priority). Setup: code_valid and i_row_valid in the same cycle. Response: the row is ignored, and the row counter is 0 on the next cycle.
REQ-035 Test 5 (mid-frame reset). Setup: assert s_rst after 3 rows of a 6-row frame. Response: all outputs 0; no o_pool_valid until a new code_valid and new rows arrive.
REQ-036 Test 6 (calculating flag). Setup: one frame of img_size=4. Response: o_calculating_flag rises the cycle after row 0 and falls the cycle after row 3.
